// File: rtl/student_dmux_stream_if.sv
// Stream bus for student_dmux_stream: one producer-side valid/ready/data/select
// channel and N consumer-side valid/ready/data channels packed into vectors.
// The slave modport is the demux's own view; master is the surrounding system.
interface student_dmux_stream_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SEL_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/student_dmux_stream.sv
// student_dmux_stream: registered N-way demultiplexer for a valid/ready stream.
// Every output channel owns a one-word holding register that drains under its
// own ready, so a stalled consumer never blocks traffic to the other channels.
// Words with an out-of-range select are dropped and raise a sticky err_sel.
// Optional per-channel saturating handshake counters (out_cnt) are compiled in
// when the macro STUDENT_DMUX_STREAM_CNT_EN is defined.
module student_dmux_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  student_dmux_stream_if.slave bus,
  output logic                 err_sel
`ifdef STUDENT_DMUX_STREAM_CNT_EN
  ,
  output logic [N*CNT_W-1:0]   out_cnt
`endif
);

  // Reject configurations the channel indexing cannot represent
  if (WIDTH < 1 || N < 2 || N > 256 || N > (1 << SEL_W) || CNT_W < 1) begin : g_bad_params
    $error("student_dmux_stream: illegal parameter combination");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t      state_q [N];
  logic [WIDTH-1:0] data_q  [N];

  logic         sel_ok;
  logic         in_ready_c;
  logic         accept;
  logic [N-1:0] load;
  logic [N-1:0] drain;

  // Ready depends only on the addressed channel; a bad select is always taken
  always_comb begin
    sel_ok     = int'(bus.in_sel) < N;
    in_ready_c = 1'b1;
    drain      = '0;
    for (int i = 0; i < N; i++) begin
      drain[i] = (state_q[i] == FULL) && bus.out_ready[i];
      if (sel_ok && int'(bus.in_sel) == i) begin
        in_ready_c = (state_q[i] == EMPTY) || bus.out_ready[i];
      end
    end
  end

  // Decode the accepted word into a one-hot load strobe
  always_comb begin
    accept = bus.in_valid && in_ready_c;
    load   = '0;
    for (int i = 0; i < N; i++) begin
      load[i] = accept && sel_ok && (int'(bus.in_sel) == i);
    end
  end

  assign bus.in_ready = in_ready_c;

  // Per-channel EMPTY/FULL holding register; a load wins over a same-edge drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          state_q[i] <= FULL;
          data_q[i]  <= bus.in_data;
        end else if (drain[i]) begin
          state_q[i] <= EMPTY;
        end
      end
    end
  end

  // Sticky error for words routed to a non-existent channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
    end else if (accept && !sel_ok) begin
      err_sel <= 1'b1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign bus.out_valid[g]                 = (state_q[g] == FULL);
    assign bus.out_data[g*WIDTH +: WIDTH]   = data_q[g];
  end

`ifdef STUDENT_DMUX_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q [N];

  // Count completed output handshakes per channel, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (drain[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign out_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: doc/student_dmux_stream.md
Name: student_dmux_stream

Overview:
- Parametrised, registered N-way demultiplexer for a valid/ready stream.
- Each input word carries a select; the block routes it into a one-entry holding register on the selected output channel.
- Each channel drains independently under its own ready.
- Sits between a producer and N consumers; successor to the fixed 1-bit 2/4/8-way combinational demux family.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- N, 8, number of output channels (2..256).
- SEL_W, 3, select width; must satisfy N <= 2**SEL_W.
- CNT_W, 8, per-channel counter width (used only when the optional feature is compiled in).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer word valid.
- in_ready  output  1  block can take the word this cycle.
- in_data  input  WIDTH  producer word.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  N  bit i: channel i holds a word.
- out_ready  input  N  bit i: consumer i takes the word this cycle.
- out_data  output  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- err_sel  output  1  sticky flag: a word with in_sel >= N was received.
- out_cnt  output  N*CNT_W  optional; channel i occupies bits [i*CNT_W +: CNT_W]; present only with the macro.

Behaviour:
- Reset (asynchronous, active-low):
  - Asserting rst_n=0 immediately clears all out_valid, out_data, err_sel and out_cnt to 0, whatever the clock is doing.
  - Any buffered words are discarded.
  - First transfer is possible on the first rising edge with rst_n=1.
- Per-channel state: two states, EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
- in_ready (combinational):
  - For in_sel < N: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - For in_sel >= N: in_ready = 1.
  - No dependence on in_valid.
- Accept: on a rising edge with in_valid && in_ready.
  - If in_sel < N: channel in_sel loads in_data and sets out_valid. Latency is 1 cycle: the word is visible on out_data the cycle after acceptance.
  - If in_sel >= N: the word is discarded, err_sel is set to 1 and stays 1 until reset. No channel changes.
- Drain: on a rising edge with out_valid[i] && out_ready[i], channel i goes FULL->EMPTY, unless it is loaded on the same edge.
- Simultaneous drain and load on the same channel: the channel stays FULL with the new word. This gives full throughput, one word per cycle per channel.
- While FULL and not ready: out_data[i] and out_valid[i] hold stable. out_valid never drops without a handshake.
- EMPTY channel: out_data[i] holds its last value (0 after reset); consumers must ignore it.
- Isolation: at most one channel is loaded per cycle. Any number of channels may drain in the same cycle.
- Backpressure on one channel never blocks words destined for other channels.
- in_valid=0: no state change except drains.
- Consumer may assert out_ready while out_valid=0; this has no effect.

Optional Feature:
- Macro: STUDENT_DMUX_STREAM_CNT_EN.
- With the macro:
  - out_cnt exists.
  - Counter i increments by 1 on each completed output handshake of channel i.
  - Counters saturate at 2**CNT_W-1 and never wrap.
  - Counters reset to 0 on rst_n.
- Without the macro: out_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle → all out_valid=0, out_data=0, err_sel=0, in_ready=1 for every in_sel; assert rst_n=0 mid-stream while channel 2 is FULL → out_valid[2]=0 immediately, before the next clk edge.
- Route burst, WIDTH=8, N=8, all out_ready=1: send 0xA0..0xA7 with in_sel=0..7 on consecutive cycles → out_valid[k] pulses one cycle after each accept with out_data[k]=0xA0+k; in_ready stays 1.
- Backpressure: out_ready[3]=0; send 0x11 to sel 3, then 0x22 to sel 3, then 0x33 to sel 5 → first accepted; second sees in_ready=0 and stalls; ch3 holds 0x11; raise out_ready[3] → 0x11 drains and 0x22 loads on the same edge; ch5 unaffected throughout.
- Full throughput on one channel, out_ready[0]=1: stream 16 words to sel 0 back-to-back → 16 consecutive output handshakes, no bubbles.
- Bad select, N=6, SEL_W=3: send 0x55 with in_sel=7 → in_ready=1, word dropped, no out_valid change, err_sel=1 from the next cycle and held until reset.
- With STUDENT_DMUX_STREAM_CNT_EN, CNT_W=2: complete 5 handshakes on ch1 → out_cnt ch1 reads 1,2,3,3,3; other channels read 0.
